// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - frame-synchronous pattern/scroll scheduler with shadowed config
module vga_frame_scheduler #(
    parameter int VSYNC_POL     = 1,
    parameter int DWELL_DEFAULT = 60,
    parameter int STEP_DEFAULT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       cfg_applied,
    output logic       frame_tick,
    output logic [1:0] pattern_sel,
    output logic [7:0] scroll,
    output logic [7:0] frame_cnt
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_APPLIED = 2'd2;
    localparam logic       VS_ACTIVE = (VSYNC_POL != 0);

    logic [1:0] state;
    logic       vsync_q;

    // Shadow set: written by the config port, committed at a frame edge.
    logic [2:0] sh_mode;
    logic [7:0] sh_step;
    logic [7:0] sh_dwell;
    logic [1:0] sh_ctrl;

    // Active set: what the pixel datapath is currently running with.
    logic [2:0] ac_mode;
    logic [7:0] ac_step;
    logic [7:0] ac_dwell;
    logic       ac_freeze;

    logic [7:0] dwell_cnt;

    logic       vsync_act;
    logic       frame_edge;
    logic       accept;
    logic       commit;
    logic [7:0] eff_step;
    logic       eff_freeze;
    logic [7:0] dwell_last;

    assign vsync_act  = (vsync == VS_ACTIVE);
    assign frame_edge = vsync_act & ~vsync_q;
    assign cfg_ready  = rst_n & (state != S_APPLIED);
    assign accept     = cfg_valid & cfg_ready;
    assign commit     = (state == S_PENDING) & frame_edge;
    assign cfg_applied = (state == S_APPLIED);

    // Scroll on a commit edge must already use the incoming step/freeze.
    assign eff_step   = commit ? sh_step    : ac_step;
    assign eff_freeze = commit ? sh_ctrl[1] : ac_freeze;
    // A dwell of zero behaves as one frame per pattern.
    assign dwell_last = (ac_dwell == 8'd0) ? 8'd0 : ac_dwell - 8'd1;

    // Frame edge detection, frame tick pulse and frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q    <= VS_ACTIVE;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            vsync_q    <= vsync_act;
            frame_tick <= frame_edge;
            if (frame_edge) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Config handshake FSM: a pending write is committed at the next frame edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (accept) state <= S_PENDING;
                S_PENDING: if (frame_edge && !accept) state <= S_APPLIED;
                S_APPLIED: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Shadow registers; a write landing on the commit edge wins over the scroll-clear self-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_mode  <= 3'd0;
            sh_step  <= 8'(STEP_DEFAULT);
            sh_dwell <= 8'(DWELL_DEFAULT);
            sh_ctrl  <= 2'd0;
        end else begin
            if (commit && sh_ctrl[0]) sh_ctrl[0] <= 1'b0;
            if (accept) begin
                case (cfg_addr)
                    2'd0: sh_mode  <= cfg_data[2:0];
                    2'd1: sh_step  <= cfg_data;
                    2'd2: sh_dwell <= cfg_data;
                    2'd3: sh_ctrl  <= cfg_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    // Active registers take the shadow values as they stood before this edge's write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ac_mode   <= 3'd0;
            ac_step   <= 8'(STEP_DEFAULT);
            ac_dwell  <= 8'(DWELL_DEFAULT);
            ac_freeze <= 1'b0;
        end else if (commit) begin
            ac_mode   <= sh_mode;
            ac_step   <= sh_step;
            ac_dwell  <= sh_dwell;
            ac_freeze <= sh_ctrl[1];
        end
    end

    // Horizontal scroll: clear on commit request, hold when frozen, else advance by step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scroll <= 8'd0;
        end else if (frame_edge) begin
            if (commit && sh_ctrl[0]) scroll <= 8'd0;
            else if (!eff_freeze)     scroll <= scroll + eff_step;
        end
    end

    // Pattern select: load on commit, otherwise auto-cycle after each dwell period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_sel <= 2'd0;
            dwell_cnt   <= 8'd0;
        end else if (commit) begin
            pattern_sel <= sh_mode[1:0];
            dwell_cnt   <= 8'd0;
        end else if (frame_edge && ac_mode[2]) begin
            if (dwell_cnt >= dwell_last) begin
                pattern_sel <= pattern_sel + 2'd1;
                dwell_cnt   <= 8'd0;
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end
endmodule
